// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the main-memory arbiter.
//            - arb_state_e : arbiter FSM states (IDLE, I_BUSY, D_BUSY)
//            - req_id_e    : requester identity (REQ_I = 0, REQ_D = 1)
//            - ADDR_W_DEF / LINE_W_DEF : default address / line widths
//            - arb_pick()  : grant decision for a cycle with eligible requests
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Fixed priority gives D the tie. With round-robin enabled the tie goes to
  // whichever requester was not granted last. The result is only meaningful
  // when at least one of elig_i / elig_d is set.
  function automatic req_id_e arb_pick(input logic    elig_i,
                                       input logic    elig_d,
                                       input logic    rr_en,
                                       input req_id_e last_grant);
    req_id_e win;
    win = REQ_I;
    if (elig_i && elig_d) begin
      if (rr_en && (last_grant == REQ_D)) win = REQ_I;
      else                                win = REQ_D;
    end else if (elig_d) begin
      win = REQ_D;
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single main-memory port between I-cache refills and
//            D-cache refills / write-backs. Latches the winning request,
//            holds the memory handshake until mem_ready, then returns the
//            line with a one-cycle done pulse. Also produces the cache stall
//            signals for the hazard unit.
// Ports    : clk, rst (async, active high)
//            I side : i_req, i_addr -> i_done, i_rdata
//            D side : d_req, d_we, d_addr, d_wdata -> d_done, d_rdata
//            Stalls : iCacheStall, dCacheStall (combinational)
//            Memory : mem_req, mem_we, mem_addr, mem_wdata <- mem_ready,
//                     mem_rdata
// Options  : MEM_ARB_RR_EN - round-robin tie-break with a last_grant
//            register; undefined gives fixed D-over-I priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              iCacheStall,
  output logic              dCacheStall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  arb_state_e        state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_done_q,    i_done_d;
  logic              d_done_q,    d_done_d;
  logic [LINE_W-1:0] i_rdata_q,   i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q,   d_rdata_d;

  // A requester whose done is high this cycle is still holding req for the
  // request just served, so it must not be granted again.
  logic    elig_i;
  logic    elig_d;
  req_id_e winner;

  assign elig_i = i_req & ~i_done_q;
  assign elig_d = d_req & ~d_done_q;

`ifdef MEM_ARB_RR_EN
  req_id_e last_grant_q, last_grant_d;
  assign winner = arb_pick(elig_i, elig_d, 1'b1, last_grant_q);
`else
  assign winner = arb_pick(elig_i, elig_d, 1'b0, REQ_I);
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (elig_i || elig_d) begin
          mem_req_d = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_grant_d = winner;
`endif
          if (winner == REQ_D) begin
            state_d     = D_BUSY;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d    = I_BUSY;
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
          end
        end
      end

      I_BUSY: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end

      D_BUSY: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          // A write-back returns no data; keep the last refilled line.
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Starts at I so that D takes the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= REQ_I;
    else     last_grant_q <= last_grant_d;
  end
`endif

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

  // Combinational so the pipeline is released in the done cycle itself.
  assign iCacheStall = i_req & ~i_done_q;
  assign dCacheStall = d_req & ~d_done_q;

endmodule
`default_nettype wire
